// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, BIST LFSR taps, BIST FSM states.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_PADDSB = 4'h1,
        OP_SUB    = 4'h2,
        OP_XOR    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_RED    = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB
    } opcode_t;

    // Feedback taps at bits 15,13,12,10 (x^16 + x^14 + x^13 + x^11 + 1).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    // Second operand for a BIST vector: byte-swapped LFSR, except the
    // byte-load opcodes only see the byte they actually consume.
    function automatic logic [15:0] bist_operand2(input logic [3:0] op, input logic [15:0] lfsr);
        logic [15:0] res;
        res = {lfsr[7:0], lfsr[15:8]};
        if (op == OP_LLB) begin
            res = {8'h00, lfsr[7:0]};
        end else if (op == OP_LHB) begin
            res = {lfsr[15:8], 8'h00};
        end
        return res;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci shift register; din XORs a parallel word in on each step (MISR use).
// Latency: one step per enabled clock; load beats step; reset is asynchronous.
// Backpressure: none; the register only moves when step or load is high.
module lfsr16
    import cpu_pkg::*;
#(
    parameter logic [15:0] TAPS    = LFSR_TAPS,
    parameter logic [15:0] RST_VAL = 16'h0001
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    input  logic [15:0] din,
    output logic [15:0] q
);

    logic fb;

    assign fb = ^(q & TAPS);

    // Shift left with feedback into bit 0, folding in the parallel input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= {q[14:0], fb} ^ din;
        end
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU self-test sequencer: sweeps opcodes with LFSR operands, compacts results into a MISR.
// Latency: passthrough is combinational; a sweep takes NUM_OPS*VEC_PER_OP cycles plus one DONE cycle.
// Backpressure: busy stalls the pipeline while the BIST owns the ALU; abort cancels at once.
module alu_bist_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned VEC_PER_OP = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000,
    parameter int unsigned NUM_OPS    = 12
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_in1,
    input  logic [15:0] ex_in2,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    input  logic [15:0] alu_out,
    input  logic        alu_ovfl,
    input  logic        alu_neg,
    input  logic        alu_zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam logic [7:0] VEC_LAST = 8'(VEC_PER_OP - 1);
    localparam logic [3:0] OP_LAST  = 4'(NUM_OPS - 1);

    bist_state_t state, state_nxt;
    logic [3:0]  op_cnt;
    logic [7:0]  vec_cnt;
    logic [15:0] lfsr_q;
    logic [15:0] misr_q;
    logic [15:0] misr_din;
    logic [15:0] bist_in2;
    logic        last_vec;
    logic        sweep_load;
    logic        lfsr_step;
    logic        misr_step;
    logic        cnt_adv;
    logic        pass_latch;
    logic        pass_q;

    assign last_vec = (op_cnt == OP_LAST) && (vec_cnt == VEC_LAST);
    assign misr_din = alu_out ^ {13'b0, alu_ovfl, alu_neg, alu_zero};

    // State register; reset drops busy immediately, handing the ALU back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and sweep control. On the final vector the LFSR and counters
    // hold so the DONE cycle keeps presenting the last vector to the ALU.
    always_comb begin
        state_nxt  = state;
        sweep_load = 1'b0;
        lfsr_step  = 1'b0;
        misr_step  = 1'b0;
        cnt_adv    = 1'b0;
        pass_latch = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt  = RUN;
                    sweep_load = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    misr_step = 1'b1;
                    if (last_vec) begin
                        state_nxt = DONE;
                    end else begin
                        lfsr_step = 1'b1;
                        cnt_adv   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (!abort) begin
                    done       = 1'b1;
                    pass_latch = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vector and opcode counters: vec_cnt wraps per opcode, op_cnt then advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt  <= 4'd0;
            vec_cnt <= 8'd0;
        end else if (sweep_load) begin
            op_cnt  <= 4'd0;
            vec_cnt <= 8'd0;
        end else if (cnt_adv) begin
            if (vec_cnt == VEC_LAST) begin
                vec_cnt <= 8'd0;
                op_cnt  <= op_cnt + 4'd1;
            end else begin
                vec_cnt <= vec_cnt + 8'd1;
            end
        end
    end

    // Pass flag: cleared by a new sweep or any abort, set from the signature at DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 1'b0;
        end else if (sweep_load || (busy && abort)) begin
            pass_q <= 1'b0;
        end else if (pass_latch) begin
            pass_q <= (misr_q == GOLDEN_SIG);
        end
    end

    lfsr16 #(
        .TAPS    (LFSR_TAPS),
        .RST_VAL (LFSR_SEED)
    ) u_operand_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sweep_load),
        .load_val (LFSR_SEED),
        .step     (lfsr_step),
        .din      (16'h0000),
        .q        (lfsr_q)
    );

    lfsr16 #(
        .TAPS    (LFSR_TAPS),
        .RST_VAL (16'h0000)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sweep_load),
        .load_val (16'h0000),
        .step     (misr_step),
        .din      (misr_din),
        .q        (misr_q)
    );

    assign bist_in2 = bist_operand2(op_cnt, lfsr_q);

    // Arbitration: pipeline operands pass straight through unless the BIST owns the ALU.
    assign busy       = (state != IDLE);
    assign alu_opcode = busy ? op_cnt   : ex_opcode;
    assign alu_in1    = busy ? lfsr_q   : ex_in1;
    assign alu_in2    = busy ? bist_in2 : ex_in2;
    assign pass       = pass_q;
    assign signature  = misr_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
module tb_alu_bist_ctrl;

    localparam int NVEC = 192;

    // Behavioural 16-bit ALU: {ovfl, neg, zero, result}.
    function automatic logic [18:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            4'h0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            4'h2: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            4'h3: r = a ^ b;
            4'h4: r = a << b[3:0];
            4'h5: r = 16'($signed(a) >>> b[3:0]);
            4'h6: r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
            4'h7: r = {8'h00, a[15:8]} + {8'h00, a[7:0]};
            4'hA: r = {a[15:8], b[7:0]};
            4'hB: r = {b[15:8], a[7:0]};
            default: r = a + b;
        endcase
        return {v, r[15], (r == 16'h0000), r};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] model_in2(input logic [3:0] op, input logic [15:0] l);
        if (op == 4'hA) return {8'h00, l[7:0]};
        if (op == 4'hB) return {l[15:8], 8'h00};
        return {l[7:0], l[15:8]};
    endfunction

    // Signature after the first nvec vectors of a sweep with vpo vectors per opcode.
    function automatic logic [15:0] sig_model(input int vpo, input int nvec);
        logic [15:0] l, m, b;
        logic [3:0]  op;
        logic [18:0] r;
        l = 16'hACE1;
        m = 16'h0000;
        for (int k = 0; k < nvec; k++) begin
            op = 4'(k / vpo);
            b  = model_in2(op, l);
            r  = alu_model(op, l, b);
            m  = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ r[15:0] ^ {13'b0, r[18:16]};
            l  = lfsr_next(l);
        end
        return m;
    endfunction

    localparam logic [15:0] SIG16 = sig_model(16, NVEC);

    logic clk = 1'b0;
    logic rst_n, start_a, start_b, abort;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_in1, ex_in2;

    logic [3:0]  alu_opcode_def, alu_opcode_gold, alu_opcode_v1;
    logic [15:0] alu_in1_def, alu_in1_gold, alu_in1_v1;
    logic [15:0] alu_in2_def, alu_in2_gold, alu_in2_v1;
    logic [18:0] alu_r_def, alu_r_gold, alu_r_v1;
    logic        busy_def, busy_gold, busy_v1;
    logic        done_def, done_gold, done_v1;
    logic        pass_def, pass_gold, pass_v1;
    logic [15:0] signature_def, signature_gold, signature_v1;

    logic [3:0]  exp_op [0:NVEC-1];
    logic [15:0] exp_in1[0:NVEC-1];
    logic [15:0] exp_in2[0:NVEC-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign alu_r_def  = alu_model(alu_opcode_def,  alu_in1_def,  alu_in2_def);
    assign alu_r_gold = alu_model(alu_opcode_gold, alu_in1_gold, alu_in2_gold);
    assign alu_r_v1   = alu_model(alu_opcode_v1,   alu_in1_v1,   alu_in2_v1);

    alu_bist_ctrl u_def (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .ex_opcode(ex_opcode), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .alu_opcode(alu_opcode_def), .alu_in1(alu_in1_def), .alu_in2(alu_in2_def),
        .alu_out(alu_r_def[15:0]), .alu_ovfl(alu_r_def[18]), .alu_neg(alu_r_def[17]), .alu_zero(alu_r_def[16]),
        .busy(busy_def), .done(done_def), .pass(pass_def), .signature(signature_def)
    );

    alu_bist_ctrl #(.GOLDEN_SIG(SIG16)) u_gold (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .ex_opcode(ex_opcode), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .alu_opcode(alu_opcode_gold), .alu_in1(alu_in1_gold), .alu_in2(alu_in2_gold),
        .alu_out(alu_r_gold[15:0]), .alu_ovfl(alu_r_gold[18]), .alu_neg(alu_r_gold[17]), .alu_zero(alu_r_gold[16]),
        .busy(busy_gold), .done(done_gold), .pass(pass_gold), .signature(signature_gold)
    );

    alu_bist_ctrl #(.VEC_PER_OP(1)) u_v1 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .ex_opcode(ex_opcode), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .alu_opcode(alu_opcode_v1), .alu_in1(alu_in1_v1), .alu_in2(alu_in2_v1),
        .alu_out(alu_r_v1[15:0]), .alu_ovfl(alu_r_v1[18]), .alu_neg(alu_r_v1[17]), .alu_zero(alu_r_v1[16]),
        .busy(busy_v1), .done(done_v1), .pass(pass_v1), .signature(signature_v1)
    );

    // Drives one sweep on u_def/u_gold and watches it cycle by cycle (bounded).
    task automatic run_a(input int restart_at, input int abort_at,
                         output int busy_n, output int done_n, output int bad_n,
                         output logic [15:0] sig_def, output logic [15:0] sig_gold);
        int idx;
        busy_n = 0; done_n = 0; bad_n = 0; sig_def = '0; sig_gold = '0;
        @(negedge clk);
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            abort   = 1'b0;
            if (!busy_def) break;
            busy_n++;
            idx = (cyc - 1 < NVEC) ? cyc - 1 : NVEC - 1;
            if (alu_opcode_def !== exp_op[idx] || alu_in1_def !== exp_in1[idx] ||
                alu_in2_def !== exp_in2[idx] || busy_gold !== 1'b1) bad_n++;
            if (done_def) begin
                done_n++;
                sig_def  = signature_def;
                sig_gold = signature_gold;
            end
            if (cyc == restart_at) start_a = 1'b1;
            if (cyc == abort_at) abort = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy_def, done_def, pass_def} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags busy/done/pass=%b required 000", {busy_def, done_def, pass_def});
        end
        n_checks++;
        if (signature_def !== 16'h0000) begin
            n_fail++; $display("FAIL reset_sig got %h required 0000", signature_def);
        end
        rst_n = 1'b1;
        @(negedge clk);
        ex_opcode = 4'h1; ex_in1 = 16'h1234; ex_in2 = 16'h0F0F;
        #1;
        n_checks++;
        if ({alu_opcode_def, alu_in1_def, alu_in2_def} !== {4'h1, 16'h1234, 16'h0F0F}) begin
            n_fail++; $display("FAIL idle_pass got %h %h %h required 1 1234 0f0f", alu_opcode_def, alu_in1_def, alu_in2_def);
        end
        n_checks++;
        if ({busy_def, done_def, pass_def, signature_def} !== 19'h0) begin
            n_fail++; $display("FAIL idle_state got busy=%b done=%b pass=%b sig=%h required all zero",
                               busy_def, done_def, pass_def, signature_def);
        end
        for (int i = 0; i < 4; i++) begin
            ex_opcode = 4'($urandom); ex_in1 = 16'($urandom); ex_in2 = 16'($urandom);
            #1;
            n_checks++;
            if ({alu_opcode_v1, alu_in1_v1, alu_in2_v1} !== {ex_opcode, ex_in1, ex_in2}) begin
                n_fail++; $display("FAIL idle_pass_rand got %h %h %h required %h %h %h",
                                   alu_opcode_v1, alu_in1_v1, alu_in2_v1, ex_opcode, ex_in1, ex_in2);
            end
        end
    endtask

    task automatic test_sequencing;
        int busy_n, done_n, done_cyc, bad_n, idx;
        logic [15:0] sig;
        logic [15:0] exp_sig;
        busy_n = 0; done_n = 0; done_cyc = 0; bad_n = 0; sig = '0;
        exp_sig = sig_model(1, 12);
        @(negedge clk);
        start_b = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (!busy_v1) break;
            busy_n++;
            idx = (cyc - 1 < 12) ? cyc - 1 : 11;
            if (alu_opcode_v1 !== 4'(idx) || alu_in1_v1 !== exp_in1[idx] ||
                alu_in2_v1 !== model_in2(4'(idx), exp_in1[idx])) bad_n++;
            if (done_v1) begin done_n++; done_cyc = cyc; sig = signature_v1; end
            if (cyc == 1) begin
                n_checks++;
                if ({alu_in1_v1, alu_in2_v1} !== {16'hACE1, 16'hE1AC}) begin
                    n_fail++; $display("FAIL first_vec got %h %h required ace1 e1ac", alu_in1_v1, alu_in2_v1);
                end
            end
            if (cyc == 11) begin
                n_checks++;
                if (alu_opcode_v1 !== 4'hA || alu_in2_v1[15:8] !== 8'h00) begin
                    n_fail++; $display("FAIL llb_in2 got op=%h in2=%h required op a, in2[15:8]=00", alu_opcode_v1, alu_in2_v1);
                end
            end
            if (cyc == 12) begin
                n_checks++;
                if (alu_opcode_v1 !== 4'hB || alu_in2_v1[7:0] !== 8'h00) begin
                    n_fail++; $display("FAIL lhb_in2 got op=%h in2=%h required op b, in2[7:0]=00", alu_opcode_v1, alu_in2_v1);
                end
            end
        end
        n_checks++;
        if (bad_n !== 0) begin n_fail++; $display("FAIL seq_vectors got %0d bad cycles required 0", bad_n); end
        n_checks++;
        if (busy_n !== 13) begin n_fail++; $display("FAIL seq_busy got %0d cycles required 13", busy_n); end
        n_checks++;
        if (done_n !== 1 || done_cyc !== 13) begin
            n_fail++; $display("FAIL seq_done got %0d pulses at cycle %0d required 1 at 13", done_n, done_cyc);
        end
        n_checks++;
        if (sig !== exp_sig) begin n_fail++; $display("FAIL seq_sig got %h required %h", sig, exp_sig); end
        n_checks++;
        if (pass_v1 !== (exp_sig == 16'h0000)) begin
            n_fail++; $display("FAIL seq_pass got %b required %b", pass_v1, (exp_sig == 16'h0000));
        end
    endtask

    task automatic test_signature;
        int busy_n, done_n, bad_n;
        logic [15:0] sd, sg;
        run_a(-1, -1, busy_n, done_n, bad_n, sd, sg);
        n_checks++;
        if (bad_n !== 0) begin n_fail++; $display("FAIL sig_vectors got %0d bad cycles required 0", bad_n); end
        n_checks++;
        if (busy_n !== NVEC + 1 || done_n !== 1) begin
            n_fail++; $display("FAIL sig_len got busy=%0d done=%0d required %0d 1", busy_n, done_n, NVEC + 1);
        end
        n_checks++;
        if (sd !== SIG16 || sg !== SIG16) begin
            n_fail++; $display("FAIL sig_value got %h %h required %h", sd, sg, SIG16);
        end
        n_checks++;
        if (pass_gold !== 1'b1) begin n_fail++; $display("FAIL pass_golden got %b required 1", pass_gold); end
        n_checks++;
        if (pass_def !== (SIG16 == 16'h0000)) begin
            n_fail++; $display("FAIL pass_zero_golden got %b required %b", pass_def, (SIG16 == 16'h0000));
        end
        n_checks++;
        if (signature_def !== SIG16) begin
            n_fail++; $display("FAIL sig_idle_hold got %h required %h", signature_def, SIG16);
        end
    endtask

    task automatic test_start_while_busy;
        int busy_n, done_n, bad_n;
        logic [15:0] sd, sg;
        run_a(5, -1, busy_n, done_n, bad_n, sd, sg);
        n_checks++;
        if (busy_n !== NVEC + 1 || done_n !== 1 || bad_n !== 0) begin
            n_fail++; $display("FAIL restart_len got busy=%0d done=%0d bad=%0d required %0d 1 0",
                               busy_n, done_n, bad_n, NVEC + 1);
        end
        n_checks++;
        if (sd !== SIG16) begin n_fail++; $display("FAIL restart_sig got %h required %h", sd, SIG16); end
    endtask

    task automatic test_abort;
        int busy_n, done_n, bad_n;
        logic [15:0] sd, sg;
        logic [15:0] part;
        part = sig_model(16, 19);
        run_a(-1, 20, busy_n, done_n, bad_n, sd, sg);
        n_checks++;
        if (busy_n !== 20 || done_n !== 0 || bad_n !== 0) begin
            n_fail++; $display("FAIL abort_len got busy=%0d done=%0d bad=%0d required 20 0 0", busy_n, done_n, bad_n);
        end
        n_checks++;
        if (pass_gold !== 1'b0 || pass_def !== 1'b0) begin
            n_fail++; $display("FAIL abort_pass got %b %b required 0 0", pass_gold, pass_def);
        end
        n_checks++;
        if (signature_def !== part) begin
            n_fail++; $display("FAIL abort_sig_kept got %h required %h", signature_def, part);
        end
        ex_opcode = 4'($urandom); ex_in1 = 16'($urandom); ex_in2 = 16'($urandom);
        #1;
        n_checks++;
        if ({alu_opcode_def, alu_in1_def, alu_in2_def} !== {ex_opcode, ex_in1, ex_in2}) begin
            n_fail++; $display("FAIL abort_release got %h %h %h required %h %h %h",
                               alu_opcode_def, alu_in1_def, alu_in2_def, ex_opcode, ex_in1, ex_in2);
        end
        @(negedge clk);
        start_a = 1'b1; abort = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy_def !== 1'b0 || signature_def !== part) begin
            n_fail++; $display("FAIL start_abort_idle got busy=%b sig=%h required 0 %h", busy_def, signature_def, part);
        end
    endtask

    task automatic test_reset_mid_run;
        int busy_n, done_n, bad_n;
        logic [15:0] sd, sg;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat ($urandom_range(10, 150)) @(negedge clk);
        ex_opcode = 4'($urandom); ex_in1 = 16'($urandom); ex_in2 = 16'($urandom);
        n_checks++;
        if (busy_def !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got %b required 1", busy_def); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy_def !== 1'b0 || busy_gold !== 1'b0 || signature_def !== 16'h0000) begin
            n_fail++; $display("FAIL async_reset got busy=%b/%b sig=%h required 0/0 0000", busy_def, busy_gold, signature_def);
        end
        n_checks++;
        if ({alu_opcode_def, alu_in1_def, alu_in2_def} !== {ex_opcode, ex_in1, ex_in2}) begin
            n_fail++; $display("FAIL async_release got %h %h %h required %h %h %h",
                               alu_opcode_def, alu_in1_def, alu_in2_def, ex_opcode, ex_in1, ex_in2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_a(-1, -1, busy_n, done_n, bad_n, sd, sg);
        n_checks++;
        if (sd !== SIG16 || done_n !== 1 || pass_gold !== 1'b1) begin
            n_fail++; $display("FAIL rerun_sig got %h done=%0d pass=%b required %h 1 1", sd, done_n, pass_gold, SIG16);
        end
    endtask

    initial begin
        logic [15:0] l;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        ex_opcode = '0; ex_in1 = '0; ex_in2 = '0;
        l = 16'hACE1;
        for (int k = 0; k < NVEC; k++) begin
            exp_op[k]  = 4'(k / 16);
            exp_in1[k] = l;
            exp_in2[k] = model_in2(4'(k / 16), l);
            l = lfsr_next(l);
        end
        test_reset;
        test_sequencing;
        test_signature;
        test_start_while_busy;
        test_abort;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
- Built-in self-test sequencer and access arbiter for the 16-bit EX-stage ALU.
- Idle: passes the EX-stage opcode and operands straight through to the ALU.
- On start: takes ownership of the ALU and stalls the pipeline. It then sweeps opcodes 0x0–0xB with LFSR-generated operands and compacts ALU_Out and the flags into a 16-bit MISR signature. The signature is compared against a golden value.

Parameters:
VEC_PER_OP, 16, vectors applied per opcode (1..256)
LFSR_SEED, 16'hACE1, operand LFSR seed (must be nonzero)
GOLDEN_SIG, 16'h0000, expected final signature
NUM_OPS, 12, opcodes swept (0x0..NUM_OPS-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin self-test; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE with no done
ex_opcode  in  4  pipeline opcode
ex_in1  in  16  pipeline operand 1
ex_in2  in  16  pipeline operand 2
alu_opcode  out  4  to ALU Opcode
alu_in1  out  16  to ALU_In1
alu_in2  out  16  to ALU_In2
alu_out  in  16  from ALU_Out
alu_ovfl  in  1  from ALU Ovfl
alu_neg  in  1  from ALU Neg
alu_zero  in  1  from ALU Zero
busy  out  1  BIST owns ALU; doubles as pipeline stall
done  out  1  one-cycle pulse at end of sweep
pass  out  1  signature == GOLDEN_SIG; valid from done until next start
signature  out  16  MISR contents

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset state: FSM=IDLE, lfsr=LFSR_SEED, misr=0, op_cnt=0, vec_cnt=0. Outputs busy=0, done=0, pass=0, signature=0.
- FSM IDLE -> RUN: start=1. That edge loads lfsr=LFSR_SEED, misr=0, both counters 0, and clears pass.
- FSM RUN -> RUN: each cycle applies one vector.
  - At the edge: misr <= {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]} ^ alu_out ^ {13'b0, alu_ovfl, alu_neg, alu_zero}.
  - At the same edge: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - vec_cnt increments and wraps at VEC_PER_OP-1; on wrap, op_cnt increments.
- FSM RUN -> DONE: on the edge that consumes the last vector (op_cnt==NUM_OPS-1, vec_cnt==VEC_PER_OP-1).
- FSM DONE -> IDLE: unconditional next cycle. done=1 for exactly this one cycle; pass latched at the same edge.
- FSM RUN/DONE -> IDLE on abort=1: misr retained, pass=0, done not asserted. abort has priority over sweep completion.
- Operand generation in RUN, combinational from state:
  - alu_opcode = op_cnt.
  - alu_in1 = lfsr.
  - alu_in2 = {lfsr[7:0], lfsr[15:8]}.
  - Exception op 0xA (LLB): alu_in2 = {8'h00, lfsr[7:0]}.
  - Exception op 0xB (LHB): alu_in2 = {lfsr[15:8], 8'h00}.
- Arbitration mux: busy=1 in RUN and DONE. When busy=0, alu_* = ex_*, with zero added latency (pure combinational path). When busy=1, alu_* = BIST operands. In DONE, alu_* holds the last vector.
- ALU timing: the ALU is combinational. The vector driven in cycle N is captured into the MISR at the end of cycle N.
- Sweep length: exactly NUM_OPS*VEC_PER_OP cycles in RUN. busy spans that count +1 (the DONE cycle).
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Reset mid-run: immediate return to reset state. busy deasserts asynchronously, releasing the ALU to the pipeline.
- signature = misr at all times. It stays stable in IDLE until the next start.

Decomposition:
- Shared package cpu_pkg:
  - opcode enum (ADD=0x0 … LHB=0xB).
  - LFSR tap constant.
  - BIST FSM state typedef {IDLE, RUN, DONE}.
- Sub-module lfsr16: step enable, synchronous load, async reset; tap set as parameter. Instantiated twice, once as the operand LFSR and once as the MISR (the MISR instance adds a parallel data-input XOR port).

Test Plan:
- Reset/idle passthrough:
  - Stimulus: assert rst_n=0, release; drive ex_opcode=4'h1, ex_in1=16'h1234, ex_in2=16'h0F0F.
  - Required: busy=0, done=0, pass=0, signature=0; alu_opcode=1, alu_in1=1234, alu_in2=0F0F in the same cycle.
- Sweep sequencing:
  - Stimulus: VEC_PER_OP=1, pulse start.
  - Required: alu_opcode steps 0x0..0xB over 12 consecutive cycles. First vector is in1=ACE1, in2=E1AC. At op 0xA, in2[15:8]=0; at op 0xB, in2[7:0]=0.
  - Required: busy high 13 cycles; done pulses once in cycle 13.
- Signature check:
  - Stimulus: default parameters with a behavioural ALU model in the bench.
  - Required: signature after done equals the bench-computed MISR. Run with GOLDEN_SIG set to that value -> pass=1; GOLDEN_SIG=16'h0000 -> pass=0.
- Start while busy:
  - Stimulus: re-pulse start at cycle 5 of a sweep.
  - Required: sweep length unchanged (NUM_OPS*VEC_PER_OP cycles); exactly one done pulse.
- Abort:
  - Stimulus: assert abort at RUN cycle 20.
  - Required: busy=0 next cycle; no done pulse; pass=0; alu_* follow ex_* again.
- Reset mid-run:
  - Stimulus: drop rst_n during RUN.
  - Required: busy=0 and signature=0 without waiting for a clock edge. A subsequent start reproduces the same signature as an uninterrupted run.
